// File: rtl/data_mem_responder.sv
// Data-memory responder: byte RAM below IO_BASE, 16-byte I/O page above it.
// I/O page holds GPIO, a prescaled compare timer and a sticky irq flag.
module data_mem_responder #(
    parameter logic [7:0] IO_BASE = 8'hF0,
    parameter int         GPIO_W  = 8
) (
    input  logic              _iClk,
    input  logic              _iReset,
    input  logic [7:0]        _iDataMemAddr,
    input  logic [7:0]        _iDataMemWData,
    input  logic              _iDataMemWrite,
    output logic [7:0]        _oDataMemRData,
    input  logic [GPIO_W-1:0] _iGpioIn,
    output logic [GPIO_W-1:0] _oGpioOut,
    output logic              _oTimerIrq
);

    localparam logic [8:0] IO_LO = {1'b0, IO_BASE};
    localparam logic [8:0] IO_HI = IO_LO + 9'd16;
    localparam int         RAM_D = int'(IO_BASE);

    logic [8:0] addr9;
    logic       ram_sel;
    logic       io_sel;
    logic [3:0] off;

    assign addr9   = {1'b0, _iDataMemAddr};
    assign ram_sel = addr9 < IO_LO;
    assign io_sel  = !ram_sel && (addr9 < IO_HI);
    assign off     = _iDataMemAddr[3:0];

    logic io_we;
    logic wr_gpo;
    logic wr_cnt;
    logic wr_cmp;
    logic wr_pre;
    logic wr_ctl;
    logic wr_sts;

    assign io_we  = _iDataMemWrite && io_sel;
    assign wr_gpo = io_we && (off == 4'h0);
    assign wr_cnt = io_we && (off == 4'h2);
    assign wr_cmp = io_we && (off == 4'h3);
    assign wr_pre = io_we && (off == 4'h4);
    assign wr_ctl = io_we && (off == 4'h5);
    assign wr_sts = io_we && (off == 4'h6);

    logic [7:0] ram_q [0:RAM_D-1];

    always_ff @(posedge _iClk) begin
        if (_iDataMemWrite && ram_sel) begin
            ram_q[_iDataMemAddr] <= _iDataMemWData;
        end
    end

    logic [GPIO_W-1:0] gpo_q, gpo_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [7:0]        count_q, count_d;
    logic [7:0]        compare_q, compare_d;
    logic [7:0]        prescale_q, prescale_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              flag_q, flag_d;
    logic              irq_q, irq_d;
    logic              tick;
    logic              hit;

    always_comb begin
        tick = ctrl_q[0] && (pcnt_q == prescale_q);
        hit  = tick && (count_q == compare_q);

        gpo_d      = wr_gpo ? _iDataMemWData[GPIO_W-1:0] : gpo_q;
        compare_d  = wr_cmp ? _iDataMemWData : compare_q;
        prescale_d = wr_pre ? _iDataMemWData : prescale_q;
        ctrl_d     = wr_ctl ? _iDataMemWData[1:0] : ctrl_q;

        pcnt_d = pcnt_q;
        if (ctrl_q[0]) begin
            pcnt_d = tick ? 8'h00 : pcnt_q + 8'h01;
        end
        if (wr_pre) begin
            pcnt_d = 8'h00;
        end

        // compare uses the pre-write COUNT/COMPARE; a COUNT write still wins
        count_d = count_q;
        if (tick) begin
            count_d = hit ? 8'h00 : count_q + 8'h01;
        end
        if (wr_cnt) begin
            count_d = 8'h00;
        end

        flag_d = flag_q;
        if (wr_sts && _iDataMemWData[0]) begin
            flag_d = 1'b0;
        end
        if (hit) begin
            flag_d = 1'b1;
        end

        irq_d = flag_q && ctrl_q[1];
    end

    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            gpo_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            count_q    <= 8'h00;
            compare_q  <= 8'h00;
            prescale_q <= 8'h00;
            pcnt_q     <= 8'h00;
            ctrl_q     <= 2'b00;
            flag_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            gpo_q      <= gpo_d;
            sync1_q    <= _iGpioIn;
            sync2_q    <= sync1_q;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            ctrl_q     <= ctrl_d;
            flag_q     <= flag_d;
            irq_q      <= irq_d;
        end
    end

    logic [7:0] gpo_ext;
    logic [7:0] gpi_ext;

    always_comb begin
        gpo_ext = 8'h00;
        gpi_ext = 8'h00;
        gpo_ext[GPIO_W-1:0] = gpo_q;
        gpi_ext[GPIO_W-1:0] = sync2_q;
    end

    always_comb begin
        _oDataMemRData = 8'h00;
        if (ram_sel) begin
            _oDataMemRData = ram_q[_iDataMemAddr];
        end else if (io_sel) begin
            case (off)
                4'h0:    _oDataMemRData = gpo_ext;
                4'h1:    _oDataMemRData = gpi_ext;
                4'h2:    _oDataMemRData = count_q;
                4'h3:    _oDataMemRData = compare_q;
                4'h4:    _oDataMemRData = prescale_q;
                4'h5:    _oDataMemRData = {6'b0, ctrl_q};
                4'h6:    _oDataMemRData = {7'b0, flag_q};
                default: _oDataMemRData = 8'h00;
            endcase
        end
    end

    assign _oGpioOut  = gpo_q;
    assign _oTimerIrq = irq_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder.
// A cycle-level reference model of the memory map runs alongside the DUT.
module tb_data_mem_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic [7:0] gin;
    logic [7:0] gout;
    logic       irq;

    int checks = 0;
    int errors = 0;

    data_mem_responder dut (
        ._iClk          (clk),
        ._iReset        (rst_n),
        ._iDataMemAddr  (addr),
        ._iDataMemWData (wdata),
        ._iDataMemWrite (we),
        ._oDataMemRData (rdata),
        ._iGpioIn       (gin),
        ._oGpioOut      (gout),
        ._oTimerIrq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] m_ram [0:255];
    logic [7:0] m_gpo, m_s1, m_s2;
    logic [7:0] m_count, m_cmp, m_pre, m_pcnt;
    logic [1:0] m_ctrl;
    logic       m_flag, m_irq;

    task automatic model_reset();
        m_gpo = 0; m_s1 = 0; m_s2 = 0;
        m_count = 0; m_cmp = 0; m_pre = 0; m_pcnt = 0;
        m_ctrl = 0; m_flag = 0; m_irq = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a < 8'hF0) return m_ram[a];
        case (a)
            8'hF0: return m_gpo;
            8'hF1: return m_s2;
            8'hF2: return m_count;
            8'hF3: return m_cmp;
            8'hF4: return m_pre;
            8'hF5: return {6'b0, m_ctrl};
            8'hF6: return {7'b0, m_flag};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic tick_now();
        return m_ctrl[0] && (m_pcnt == m_pre);
    endfunction

    task automatic model_step(input logic w, input logic [7:0] a,
                              input logic [7:0] d);
        logic       t, h, nf;
        logic [7:0] nc, np;
        t  = tick_now();
        h  = t && (m_count == m_cmp);
        nc = t ? (h ? 8'h00 : m_count + 8'd1) : m_count;
        np = m_ctrl[0] ? (t ? 8'h00 : m_pcnt + 8'd1) : m_pcnt;
        nf = m_flag;
        m_irq = m_flag & m_ctrl[1];
        m_s2 = m_s1;
        m_s1 = gin;
        if (w) begin
            if (a < 8'hF0) m_ram[a] = d;
            case (a)
                8'hF0: m_gpo = d;
                8'hF2: nc = 0;
                8'hF3: m_cmp = d;
                8'hF4: begin m_pre = d; np = 0; end
                8'hF5: m_ctrl = d[1:0];
                8'hF6: if (d[0]) nf = 0;
                default: ;
            endcase
        end
        if (h) nf = 1;
        m_count = nc;
        m_pcnt = np;
        m_flag = nf;
    endtask

    task automatic drive(input logic w, input logic [7:0] a,
                         input logic [7:0] d);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_step(we, addr, wdata);
    endtask

    task automatic test_reset();
        rst_n = 0; we = 0; addr = 8'hF0; wdata = 0; gin = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (gout !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_out gout=%h irq=%b want 00/0", gout, irq);
        end
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 8'(8'hF0 + i), 0);
            checks++;
            if (rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h want=00", i, rdata);
            end
            step();
        end
        for (int a = 0; a < 240; a++) begin
            drive(1, 8'(a), 8'($urandom));
            step();
        end
    endtask

    task automatic test_ram();
        logic [7:0] old;
        logic [7:0] ta [3];
        logic [7:0] td [3];
        ta[0] = 8'h10; td[0] = 8'h5A;
        ta[1] = 8'hEF; td[1] = 8'h3C;
        ta[2] = 8'h00; td[2] = 8'h96;
        for (int i = 0; i < 3; i++) begin
            old = m_ram[ta[i]];
            drive(1, ta[i], td[i]);
            checks++;
            if (rdata !== old) begin
                errors++;
                $display("FAIL ram_rdw a=%h got=%h want=%h", ta[i], rdata, old);
            end
            step();
            drive(0, ta[i], 8'h00);
            checks++;
            if (rdata !== td[i]) begin
                errors++;
                $display("FAIL ram_rd a=%h got=%h want=%h", ta[i], rdata, td[i]);
            end
            step();
        end
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom), 8'($urandom_range(0, 239)), 8'($urandom));
            checks++;
            if (rdata !== m_read(addr)) begin
                errors++;
                $display("FAIL ram_rand a=%h got=%h want=%h",
                         addr, rdata, m_read(addr));
            end
            step();
        end
    endtask

    task automatic test_gpio();
        drive(1, 8'hF0, 8'hC3);
        step();
        drive(0, 8'hF1, 0);
        checks++;
        if (gout !== 8'hC3) begin
            errors++;
            $display("FAIL gpio_out got=%h want=c3", gout);
        end
        gin = 8'hA5;
        step();
        drive(0, 8'hF1, 0);
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL gpio_in_1edge got=%h want=00", rdata);
        end
        step();
        drive(0, 8'hF1, 0);
        checks++;
        if (rdata !== 8'hA5) begin
            errors++;
            $display("FAIL gpio_in_2edge got=%h want=a5", rdata);
        end
        step();
    endtask

    task automatic test_timer();
        logic [7:0] want;
        drive(1, 8'hF2, 0); step();
        drive(1, 8'hF4, 2); step();
        drive(1, 8'hF3, 3); step();
        drive(1, 8'hF5, 3); step();
        for (int k = 0; k <= 13; k++) begin
            want = 8'((k / 3) % 4);
            drive(0, 8'hF2, 0);
            checks++;
            if (rdata !== want || irq !== (k >= 13)) begin
                errors++;
                $display("FAIL timer_seq k=%0d count=%h irq=%b want %h/%b",
                         k, rdata, irq, want, k >= 13);
            end
            step();
        end
        drive(1, 8'hF6, 8'h01);
        checks++;
        if (rdata !== 8'h01) begin
            errors++;
            $display("FAIL timer_flag got=%h want=01", rdata);
        end
        step();
        drive(0, 8'hF6, 0);
        checks++;
        if (rdata !== 8'h00 || irq !== 1'b1) begin
            errors++;
            $display("FAIL timer_w1c flag=%h irq=%b want 00/1", rdata, irq);
        end
        step();
        drive(0, 8'hF6, 0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL timer_irq_drop got=%b want=0", irq);
        end
        step();
    endtask

    task automatic test_simul();
        int  n;
        logic [7:0] c;
        n = 0;
        while (!(tick_now() && m_count == m_cmp) && n < 60) begin
            drive(0, 8'hF2, 0); step(); n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL sim_w1c_wait got=timeout want=match");
        end else begin
            drive(1, 8'hF6, 8'h01); step();
            drive(0, 8'hF6, 0);
            if (rdata !== 8'h01) begin
                errors++;
                $display("FAIL sim_w1c_set got=%h want=01", rdata);
            end
            step();
        end
        n = 0;
        while (!(tick_now() && m_count != m_cmp) && n < 60) begin
            drive(0, 8'hF2, 0); step(); n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL sim_cnt_wait got=timeout want=tick");
        end else begin
            drive(1, 8'hF2, 8'h55); step();
            drive(0, 8'hF2, 0);
            if (rdata !== 8'h00) begin
                errors++;
                $display("FAIL sim_cnt_wr got=%h want=00", rdata);
            end
            step();
        end
        drive(1, 8'hF6, 8'h01); step();
        n = 0;
        while (!(tick_now() && m_count == m_cmp) && n < 60) begin
            drive(0, 8'hF2, 0); step(); n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL sim_cmp_wait got=timeout want=match");
        end else begin
            c = m_count;
            drive(1, 8'hF3, 8'h10); step();
            drive(0, 8'hF2, 0);
            if (rdata !== 8'h00 || m_flag !== 1'b1) begin
                errors++;
                $display("FAIL sim_cmp_wr count=%h oldcnt=%h want=00", rdata, c);
            end
            step();
            drive(0, 8'hF6, 0);
            checks++;
            if (rdata !== 8'h01) begin
                errors++;
                $display("FAIL sim_cmp_flag got=%h want=01", rdata);
            end
            step();
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] ua [3];
        ua[0] = 8'hF1; ua[1] = 8'hF8; ua[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            drive(1, ua[i], 8'($urandom | 1)); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, ua[i], 0);
            checks++;
            if (rdata !== ((i == 0) ? gin : 8'h00)) begin
                errors++;
                $display("FAIL unmapped a=%h got=%h want=%h",
                         ua[i], rdata, (i == 0) ? gin : 8'h00);
            end
            step();
        end
        for (int a = 0; a < 240; a++) begin
            drive(0, 8'(a), 0);
            checks++;
            if (rdata !== m_ram[a]) begin
                errors++;
                $display("FAIL ram_keep a=%h got=%h want=%h", a, rdata, m_ram[a]);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom % 2) ? 8'($urandom_range(240, 255))
                               : 8'($urandom_range(0, 239));
            drive(($urandom % 10) < 3, a, 8'($urandom));
            if (a == 8'hF4) wdata = 8'($urandom_range(0, 3));
            gin = 8'($urandom);
            checks++;
            if (rdata !== m_read(a) || gout !== m_gpo || irq !== m_irq) begin
                errors++;
                $display("FAIL rand i=%0d a=%h rd=%h gp=%h irq=%b want %h/%h/%b",
                         i, a, rdata, gout, irq, m_read(a), m_gpo, m_irq);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        int n;
        drive(1, 8'hF0, 8'h5A); step();
        drive(1, 8'hF4, 0); step();
        drive(1, 8'hF3, 5); step();
        drive(1, 8'hF2, 0); step();
        drive(1, 8'hF6, 1); step();
        drive(1, 8'hF5, 3); step();
        n = 0;
        while (!(m_count == 2 && m_flag && m_irq) && n < 40) begin
            drive(0, 8'hF2, 0); step(); n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL arst_wait got=timeout want=count2");
        end
        @(negedge clk);
        we = 0; addr = 8'hF2;
        #2 rst_n = 0;
        #1;
        checks++;
        if (gout !== 8'h00 || irq !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL arst_now gout=%h irq=%b count=%h want 00/0/00",
                     gout, irq, rdata);
        end
        addr = 8'hF6;
        #1;
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL arst_flag got=%h want=00", rdata);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int a = 0; a < 240; a++) begin
            drive(0, 8'(a), 0);
            checks++;
            if (rdata !== m_ram[a]) begin
                errors++;
                $display("FAIL arst_ram a=%h got=%h want=%h", a, rdata, m_ram[a]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_timer();
        test_simul();
        test_unmapped();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. Sits between the CPU core's data-RAM port and the board.
- Serves a byte-addressed RAM in the low address space, plus a memory-mapped I/O page at the top: GPIO out, synchronised GPIO in, a prescaled timer and a sticky interrupt flag.
- Meets the core's timing: the address is stable for a full cycle before it is sampled; the write strobe is high for exactly one cycle.

Parameters:
- IO_BASE, 8'hF0, first I/O address. RAM occupies 0 to IO_BASE-1. Must be a multiple of 16 and at most 8'hF0.
- GPIO_W, 8, width of the GPIO in/out buses (1..8). Unused upper register bits read 0.

Ports:
- _iClk  in  1  system clock, all logic on rising edge
- _iReset  in  1  asynchronous, active-low reset
- _iDataMemAddr  in  8  byte address from core
- _iDataMemWData  in  8  write data from core
- _iDataMemWrite  in  1  write strobe, one cycle per store
- _oDataMemRData  out  8  read data, combinational from _iDataMemAddr and current register/RAM state
- _iGpioIn  in  GPIO_W  asynchronous board inputs
- _oGpioOut  out  GPIO_W  registered board outputs
- _oTimerIrq  out  1  registered; equals STATUS.flag AND CTRL.irqEn

Behaviour:
- Reset (_iReset low, async):
  - _oGpioOut=0, _oTimerIrq=0; all I/O registers 0.
  - Sync flops 0; prescale counter 0.
  - RAM contents are not reset.
- Read:
  - Asynchronous/combinational; zero-cycle latency from address.
  - Read-during-write at the same address returns the old value; the new value is visible the cycle after the write edge.
- Write: on the rising edge with _iDataMemWrite=1. RAM or register updated at that edge.
- Memory map (offset from IO_BASE):
  - 0x0 GPIO_OUT (R/W): drives _oGpioOut.
  - 0x1 GPIO_IN (RO): 2-flop synchronised _iGpioIn; 2-cycle latency; writes ignored.
  - 0x2 COUNT (R): timer count. Any write clears it to 0.
  - 0x3 COMPARE (R/W).
  - 0x4 PRESCALE (R/W).
  - 0x5 CTRL (R/W): bit0 timerEn, bit1 irqEn, others read 0.
  - 0x6 STATUS: bit0 flag, sticky; write 1 to clear, write 0 has no effect.
  - 0x7..0xF: read 8'h00; writes ignored.
  - Addresses IO_BASE+16 to 0xFF (if any): read 8'h00; writes ignored.
- Prescaler:
  - When timerEn=1, pcnt increments each clock.
  - When pcnt==PRESCALE, pcnt<=0 and a one-cycle tick is asserted. The tick rate is clk/(PRESCALE+1); PRESCALE=0 gives a tick every cycle.
  - When timerEn=0, pcnt holds and no ticks occur.
  - A write to PRESCALE also clears pcnt.
- Timer, on each tick:
  - If COUNT==COMPARE: COUNT<=0 and flag<=1.
  - Otherwise COUNT<=COUNT+1. Arithmetic is 8-bit and wraps 0xFF->0x00 with no flag (reachable only if COMPARE is lowered below COUNT).
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins (COUNT=0); the flag is still set if the pre-write COUNT==COMPARE.
  - STATUS W1C and a flag-set in the same cycle: set wins (flag stays 1).
  - COMPARE write and tick in the same cycle: the tick compares against the old COMPARE.
- _oTimerIrq is registered: it follows flag&irqEn one cycle after either changes.
- Reset mid-operation: all registers return to reset values immediately. The first tick occurs PRESCALE+1 cycles after timerEn is set.

Test Plan:
- Reset then write sequence: write 8'h5A to addr 0x10; the read returns 8'h5A from the next cycle. A same-cycle read of 0x10 during the write returns the old value. Write 0xEF/0x00 boundaries likewise.
- GPIO:
  - Write 8'hC3 to 0xF0 -> _oGpioOut=8'hC3 the cycle after.
  - Drive _iGpioIn=8'hA5 -> reading 0xF1 returns 8'hA5 after exactly 2 edges, and still the old value after 1.
- Timer:
  - Setup: PRESCALE=2, COMPARE=3, CTRL=8'h03.
  - COUNT steps 0,1,2,3 every 3 cycles; on the tick after 3, COUNT=0 and flag=1.
  - _oTimerIrq goes high one cycle later.
  - Write 8'h01 to 0xF6 -> flag=0 and the irq drops the next cycle.
- Simultaneity:
  - STATUS W1C on the same edge as a compare-match tick -> flag stays 1.
  - COUNT write on a tick edge -> COUNT=0.
- Unmapped/RO:
  - Write to 0xF1, 0xF8 and 0xFF, then read -> all return 0 (0xF1 returns the synchronised input).
  - No RAM location changes.
- Async reset asserted mid-count (COUNT=2, flag=1) -> outputs and registers are 0 without a clock edge. After release, RAM retains previously written data.
